// File: rtl/osc_freq_monitor_pkg.sv
// rtl/osc_freq_monitor_pkg.sv - shared types, widths and range check for the oscillator frequency monitor
package osc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int DEF_REF_PERIODS = 16;
    localparam int DEF_TIMEOUT     = 4096;

    // Width needed to hold edge indices 0..n-1 (at least one bit).
    function automatic int edge_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold timeout values 0..t.
    function automatic int to_width(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int EDGE_W = edge_width(DEF_REF_PERIODS);
    localparam int TO_W   = to_width(DEF_TIMEOUT);

    // |cnt - exp_cnt| <= tol on a signed difference one bit wider than the
    // widest supported count, so the subtraction can never wrap.
    function automatic logic range_ok(input logic [31:0] cnt,
                                      input logic [31:0] exp_cnt,
                                      input logic [31:0] tol,
                                      input logic        sat);
        logic signed [32:0] diff;
        diff = $signed({1'b0, cnt}) - $signed({1'b0, exp_cnt});
        if (diff < 0) begin
            diff = -diff;
        end
        return !sat && (diff <= $signed({1'b0, tol}));
    endfunction

endpackage

// File: rtl/osc_freq_monitor_if.sv
// rtl/osc_freq_monitor_if.sv - control and result bundle of the oscillator frequency monitor
interface osc_freq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             EN;
    logic             REF_IN;
    logic [CNT_W-1:0] COUNT;
    logic             VALID;
    logic             IN_RANGE;
    logic             REF_DEAD;
    logic             BUSY;

    modport slave (
        input  EN, REF_IN,
        output COUNT, VALID, IN_RANGE, REF_DEAD, BUSY
    );

    modport master (
        output EN, REF_IN,
        input  COUNT, VALID, IN_RANGE, REF_DEAD, BUSY
    );
endinterface

// File: rtl/osc_freq_monitor_sync_edge.sv
// rtl/osc_freq_monitor_sync_edge.sv - two-flop synchronizer with rising-edge detect for oscillator taps
module osc_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);
    logic       sync1_q;
    logic       sync2_q;
    logic       sync3_q;
    logic [1:0] fill_q;

    // Synchronize the tap and track when the edge-detect flop holds a real
    // sample, so a tap that is already high out of reset is not a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign edge_o = sync2_q & ~sync3_q & (fill_q == 2'd3);
endmodule

// File: rtl/osc_freq_monitor.sv
// rtl/osc_freq_monitor.sv - counts fabric cycles across reference periods with range check and dead-reference flag
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int REF_PERIODS = DEF_REF_PERIODS,
    parameter int CNT_W       = 16,
    parameter int EXP_COUNT   = 800,
    parameter int TOL         = 16,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                RESET,
    osc_freq_monitor_if.slave   mon
);
    localparam int EW = edge_width(REF_PERIODS);
    localparam int TW = to_width(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [EW-1:0]    LAST_EDGE = EW'(REF_PERIODS - 1);
    localparam logic [TW-1:0]    TO_LIMIT  = TW'(TIMEOUT);

    if (longint'(EXP_COUNT) + longint'(TOL) > (longint'(1) << CNT_W) - 1) begin : g_bad_cfg
        $error("osc_freq_monitor: EXP_COUNT + TOL does not fit in CNT_W bits");
    end

    logic             ref_edge;
    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cyc_q,    cyc_d;
    logic [EW-1:0]    ecnt_q,   ecnt_d;
    logic [TW-1:0]    to_q,     to_d;
    logic             sat_q,    sat_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             valid_q,  valid_d;
    logic             inr_q,    inr_d;
    logic             dead_q,   dead_d;
    logic [CNT_W-1:0] cyc_inc;
    logic             cyc_wrap;

    osc_sync_edge u_sync_edge (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .async_i (mon.REF_IN),
        .edge_o  (ref_edge)
    );

    assign cyc_wrap = (cyc_q == CNT_MAX);
    assign cyc_inc  = cyc_wrap ? CNT_MAX : cyc_q + CNT_W'(1);

    // Next-state and window bookkeeping; EN loss beats a terminating edge,
    // and an edge beats a timeout on the same cycle.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ecnt_d  = ecnt_q;
        to_d    = to_q;
        sat_d   = sat_q;
        count_d = count_q;
        inr_d   = inr_q;
        dead_d  = dead_q;
        valid_d = 1'b0;

        if (!mon.EN) begin
            dead_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cyc_d  = '0;
                ecnt_d = '0;
                to_d   = '0;
                sat_d  = 1'b0;
                if (mon.EN) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!mon.EN) begin
                    state_d = IDLE;
                    to_d    = '0;
                end else if (ref_edge) begin
                    state_d = MEASURE;
                    cyc_d   = '0;
                    ecnt_d  = '0;
                    to_d    = '0;
                    sat_d   = 1'b0;
                end else if (to_q == TO_LIMIT) begin
                    dead_d = 1'b1;
                    to_d   = '0;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            MEASURE: begin
                if (!mon.EN) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    ecnt_d  = '0;
                    to_d    = '0;
                    sat_d   = 1'b0;
                end else if (ref_edge) begin
                    to_d = '0;
                    if (ecnt_q == LAST_EDGE) begin
                        // Terminating edge also arms the next window.
                        count_d = cyc_inc;
                        inr_d   = range_ok(32'(cyc_inc), 32'(EXP_COUNT), 32'(TOL),
                                           sat_q | cyc_wrap);
                        valid_d = 1'b1;
                        cyc_d   = '0;
                        ecnt_d  = '0;
                        sat_d   = 1'b0;
                    end else begin
                        ecnt_d = ecnt_q + EW'(1);
                        cyc_d  = cyc_inc;
                        sat_d  = sat_q | cyc_wrap;
                    end
                end else if (to_q == TO_LIMIT) begin
                    dead_d  = 1'b1;
                    state_d = ARM;
                    cyc_d   = '0;
                    ecnt_d  = '0;
                    to_d    = '0;
                    sat_d   = 1'b0;
                end else begin
                    to_d  = to_q + TW'(1);
                    cyc_d = cyc_inc;
                    sat_d = sat_q | cyc_wrap;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            ecnt_q  <= '0;
            to_q    <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            inr_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ecnt_q  <= ecnt_d;
            to_q    <= to_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            valid_q <= valid_d;
            inr_q   <= inr_d;
            dead_q  <= dead_d;
        end
    end

    assign mon.COUNT    = count_q;
    assign mon.VALID    = valid_q;
    assign mon.IN_RANGE = inr_q;
    assign mon.REF_DEAD = dead_q;
    assign mon.BUSY     = (state_q != IDLE);
endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb/tb_osc_freq_monitor.sv - self-checking bench for osc_freq_monitor
module tb_osc_freq_monitor;
    localparam int CLK_NS  = 20;
    localparam int NPER    = 16;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    osc_freq_monitor_if #(.CNT_W(16)) ifc ();
    osc_freq_monitor_if #(.CNT_W(8))  ifs ();

    osc_freq_monitor #(.REF_PERIODS(NPER), .CNT_W(16), .EXP_COUNT(800), .TOL(16), .TIMEOUT(TIMEOUT))
        dut (.CLK(clk), .RESET(rst), .mon(ifc));

    osc_freq_monitor #(.REF_PERIODS(NPER), .CNT_W(8), .EXP_COUNT(200), .TOL(10), .TIMEOUT(TIMEOUT))
        dut_s (.CLK(clk), .RESET(rst), .mon(ifs));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned per_ns = 1000;
    bit gen_run = 1'b0;
    bit gen_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: cycles in NPER periods, saturated to the count width.
    function automatic int unsigned model_raw(input int unsigned p);
        return (NPER * p) / CLK_NS;
    endfunction
    function automatic int unsigned model_count(input int unsigned p, input int w);
        int unsigned mx = (1 << w) - 1;
        return (model_raw(p) > mx) ? mx : model_raw(p);
    endfunction
    function automatic bit model_inr(input int unsigned p, input int w, input int e, input int t);
        int c = int'(model_count(p, w));
        int d = (c > e) ? c - e : e - c;
        return (model_raw(p) <= (1 << w) - 1) && (d <= t);
    endfunction

    // Reference oscillator; rises land 1 ns after a falling CLK edge.
    initial begin
        ifc.REF_IN = 1'b0;
        ifs.REF_IN = 1'b0;
        forever begin
            wait (gen_run);
            gen_busy = 1'b1;
            @(posedge clk);
            #11;
            while (gen_run) begin
                ifc.REF_IN = 1'b1;
                ifs.REF_IN = 1'b1;
                last_rise_cyc = cyc;
                #(per_ns / 2);
                ifc.REF_IN = 1'b0;
                ifs.REF_IN = 1'b0;
                #(per_ns / 2);
            end
            gen_busy = 1'b0;
        end
    end

    task automatic start_gen(input int unsigned p);
        per_ns  = p;
        gen_run = 1'b1;
    endtask

    task automatic stop_gen();
        gen_run = 1'b0;
        for (int i = 0; i < 200 && gen_busy; i++) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit got, output int unsigned at);
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.VALID) begin
                got = 1'b1;
                at  = cyc;
                return;
            end
        end
    endtask

    task automatic restart(input int unsigned p);
        @(negedge clk);
        ifc.EN = 1'b0;
        stop_gen();
        repeat (2) @(negedge clk);
        start_gen(p);
        ifc.EN = 1'b1;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({ifc.COUNT, ifc.VALID, ifc.IN_RANGE, ifc.REF_DEAD, ifc.BUSY} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_main: got %h want 0", {ifc.COUNT, ifc.VALID, ifc.IN_RANGE, ifc.REF_DEAD, ifc.BUSY});
        end
        n_cmp++;
        if ({ifs.COUNT, ifs.VALID, ifs.IN_RANGE, ifs.REF_DEAD, ifs.BUSY} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_small: got %h want 0", {ifs.COUNT, ifs.VALID, ifs.IN_RANGE, ifs.REF_DEAD, ifs.BUSY});
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit got;
        int unsigned v1, v2, en_at;
        start_gen(1000);
        @(negedge clk);
        ifc.EN = 1'b1;
        ifs.EN = 1'b1;
        en_at = cyc;
        wait_valid(2000, got, v1);
        n_cmp++;
        if (!got || (v1 - en_at) <= 800 || (v1 - en_at) > 900) begin
            n_bad++;
            $display("FAIL nom_first_latency: got=%0d cycles=%0d want 801..900", got, v1 - en_at);
        end
        n_cmp++;
        if (ifc.COUNT !== 16'(model_count(1000, 16)) || ifc.IN_RANGE !== model_inr(1000, 16, 800, 16)) begin
            n_bad++;
            $display("FAIL nom_count: got %0d/%0d want %0d/%0d", ifc.COUNT, ifc.IN_RANGE,
                     model_count(1000, 16), model_inr(1000, 16, 800, 16));
        end
        n_cmp++;
        if (ifs.VALID !== 1'b1 || ifs.COUNT !== 8'(model_count(1000, 8)) || ifs.IN_RANGE !== model_inr(1000, 8, 200, 10)) begin
            n_bad++;
            $display("FAIL sat_count: got v=%0d %0d/%0d want v=1 %0d/%0d", ifs.VALID, ifs.COUNT, ifs.IN_RANGE,
                     model_count(1000, 8), model_inr(1000, 8, 200, 10));
        end
        wait_valid(1000, got, v2);
        n_cmp++;
        if (!got || (v2 - v1) != model_raw(1000)) begin
            n_bad++;
            $display("FAIL nom_interval: got=%0d interval=%0d want %0d", got, v2 - v1, model_raw(1000));
        end
        n_cmp++;
        if (ifc.COUNT !== 16'(model_count(1000, 16))) begin
            n_bad++;
            $display("FAIL nom_count2: got %0d want %0d", ifc.COUNT, model_count(1000, 16));
        end
        ifs.EN = 1'b0;
    endtask

    task automatic test_periods();
        int unsigned plist [6];
        bit got;
        int unsigned v1, v2;
        plist[0] = 1040;
        plist[1] = 1010;
        for (int i = 2; i < 6; i++) plist[i] = 10 * $urandom_range(95, 106);
        for (int i = 0; i < 6; i++) begin
            restart(plist[i]);
            wait_valid(3000, got, v1);
            n_cmp++;
            if (!got || ifc.COUNT !== 16'(model_count(plist[i], 16))) begin
                n_bad++;
                $display("FAIL per_count p=%0d: got=%0d count=%0d want %0d", plist[i], got, ifc.COUNT, model_count(plist[i], 16));
            end
            n_cmp++;
            if (ifc.IN_RANGE !== model_inr(plist[i], 16, 800, 16)) begin
                n_bad++;
                $display("FAIL per_inrange p=%0d: got %0d want %0d", plist[i], ifc.IN_RANGE, model_inr(plist[i], 16, 800, 16));
            end
            wait_valid(1500, got, v2);
            n_cmp++;
            if (!got || (v2 - v1) != model_raw(plist[i])) begin
                n_bad++;
                $display("FAIL per_interval p=%0d: got=%0d interval=%0d want %0d", plist[i], got, v2 - v1, model_raw(plist[i]));
            end
        end
    endtask

    task automatic test_timeout();
        bit got, dead_seen;
        int unsigned v1, dead_at, nvalid;
        restart(1000);
        wait_valid(2000, got, v1);
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL to_prewindow: got no VALID want one");
        end
        stop_gen();
        dead_seen = 1'b0;
        dead_at   = 0;
        nvalid    = 0;
        for (int i = 0; i < 6000 && !dead_seen; i++) begin
            @(negedge clk);
            if (ifc.VALID) nvalid++;
            if (ifc.REF_DEAD) begin
                dead_seen = 1'b1;
                dead_at   = cyc;
            end
        end
        n_cmp++;
        if (!dead_seen || dead_at != last_rise_cyc + 3 + TIMEOUT + 1) begin
            n_bad++;
            $display("FAIL to_dead_time: seen=%0d at=%0d want %0d", dead_seen, dead_at, last_rise_cyc + 3 + TIMEOUT + 1);
        end
        n_cmp++;
        if (nvalid != 0) begin
            n_bad++;
            $display("FAIL to_no_valid: got %0d VALIDs want 0", nvalid);
        end
        start_gen(1000);
        repeat (2000) @(negedge clk);
        n_cmp++;
        if (ifc.REF_DEAD !== 1'b1 || ifc.BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: got dead=%0d busy=%0d want 1/1", ifc.REF_DEAD, ifc.BUSY);
        end
        ifc.EN = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifc.REF_DEAD !== 1'b0 || ifc.BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL to_clear: got dead=%0d busy=%0d want 0/0", ifc.REF_DEAD, ifc.BUSY);
        end
    endtask

    task automatic test_en_drop();
        bit got;
        int unsigned v1, nvalid;
        restart(1000);
        wait_valid(2000, got, v1);
        n_cmp++;
        if (!got || ifc.COUNT !== 16'd800) begin
            n_bad++;
            $display("FAIL en_pre: got=%0d count=%0d want 800", got, ifc.COUNT);
        end
        repeat (400) @(negedge clk);
        ifc.EN = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ifc.VALID) nvalid++;
        end
        n_cmp++;
        if (nvalid != 0 || ifc.BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL en_discard: got valids=%0d busy=%0d want 0/0", nvalid, ifc.BUSY);
        end
        n_cmp++;
        if (ifc.COUNT !== 16'd800 || ifc.IN_RANGE !== 1'b1) begin
            n_bad++;
            $display("FAIL en_hold: got %0d/%0d want 800/1", ifc.COUNT, ifc.IN_RANGE);
        end
        ifc.EN = 1'b1;
        wait_valid(2000, got, v1);
        n_cmp++;
        if (!got || ifc.COUNT !== 16'd800 || ifc.IN_RANGE !== 1'b1) begin
            n_bad++;
            $display("FAIL en_resume: got=%0d %0d/%0d want 800/1", got, ifc.COUNT, ifc.IN_RANGE);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int unsigned v1, rel;
        wait_valid(2000, got, v1);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ifc.COUNT, ifc.VALID, ifc.IN_RANGE, ifc.REF_DEAD, ifc.BUSY} !== 20'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got %h want 0", {ifc.COUNT, ifc.VALID, ifc.IN_RANGE, ifc.REF_DEAD, ifc.BUSY});
        end
        rst = 1'b0;
        rel = cyc;
        wait_valid(3000, got, v1);
        n_cmp++;
        if (!got || (v1 - rel) <= 800 || (v1 - rel) > 900) begin
            n_bad++;
            $display("FAIL rst_latency: got=%0d cycles=%0d want 801..900", got, v1 - rel);
        end
        n_cmp++;
        if (ifc.COUNT !== 16'd800 || ifc.IN_RANGE !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_count: got %0d/%0d want 800/1", ifc.COUNT, ifc.IN_RANGE);
        end
    endtask

    initial begin
        ifc.EN = 1'b0;
        ifs.EN = 1'b0;
        test_reset();
        test_nominal();
        test_periods();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        stop_gen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/osc_freq_monitor.md
Name: osc_freq_monitor

Overview:
- Measures a slow on-chip oscillator output (RCOSC_1MHZ_O2F or XTLOSC_O2F) against the fabric clock derived from the 25/50 MHz RC oscillator.
- Counts CLK cycles across REF_PERIODS reference periods and reports the count plus a pass/fail range check.
- Flags a dead reference oscillator.
- Sits downstream of the oscillator wrapper and feeds the system-health/status logic.

Parameters:
- REF_PERIODS, 16: reference rising edges per measurement window.
- CNT_W, 16: width of the cycle counter and COUNT.
- EXP_COUNT, 800: expected COUNT. 50 MHz CLK, 1 MHz ref, 16 periods gives 800.
- TOL, 16: allowed absolute deviation from EXP_COUNT.
- TIMEOUT, 4096: CLK cycles without a reference edge before REF_DEAD is set.

Ports:
- CLK, input, 1: fabric clock; all logic is in this domain.
- RESET, input, 1: synchronous, active-high reset.
- EN, input, 1: enables measurement.
- REF_IN, input, 1: asynchronous slow oscillator, sampled as data.
- COUNT, output, CNT_W: last completed window count.
- VALID, output, 1: one-cycle pulse when COUNT and IN_RANGE update.
- IN_RANGE, output, 1: high when |COUNT - EXP_COUNT| <= TOL and no saturation occurred.
- REF_DEAD, output, 1: sticky reference-timeout flag.
- BUSY, output, 1: high in ARM or MEASURE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Synchronizer flops, edge-detect flop and all counters are 0.
- Input path:
  - REF_IN passes through a 2-flop synchronizer, then a rising-edge detect (sync2 & ~sync3).
  - Edge pulse appears 3 CLK cycles after a REF_IN rise.
  - After reset, a REF_IN that is already high needs a fall and a rise before the first edge is seen.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: EN=1 goes to ARM next cycle.
  - ARM: waits for an edge. On an edge, go to MEASURE with cyc_cnt=0 and edge_cnt=0.
  - MEASURE: cyc_cnt increments every cycle and saturates at 2^CNT_W-1; a sticky sat flag is set on saturation. Each edge increments edge_cnt.
- Window end (edge_cnt reaches REF_PERIODS-1 and an edge is seen):
  - COUNT <= cyc_cnt+1, saturating.
  - IN_RANGE is computed from that value and !sat.
  - VALID=1 on the following cycle, the same cycle COUNT changes; registered outputs.
  - The terminating edge becomes the arming edge of the next window. Counters are cleared and the FSM stays in MEASURE, so windows run back-to-back with no gap.
- Arithmetic:
  - The range check uses CNT_W+1-bit signed difference. No wrap.
  - EXP_COUNT+TOL must fit in CNT_W bits; check this at elaboration.
- Timeout:
  - to_cnt counts cycles since the last edge in ARM or MEASURE and clears on each edge.
  - When to_cnt reaches TIMEOUT: REF_DEAD <= 1, FSM goes to ARM, and no VALID is issued for the aborted window.
  - REF_DEAD stays set until EN=0 or RESET, even if edges resume.
- EN dropped in ARM or MEASURE:
  - FSM goes to IDLE next cycle and the window is discarded; no VALID.
  - COUNT and IN_RANGE keep their last values.
  - REF_DEAD clears.
- Simultaneous events:
  - Terminating edge on the same cycle as EN falling: EN wins, no VALID.
  - Edge on the same cycle as to_cnt reaching TIMEOUT: the edge wins and REF_DEAD is not set.
- RESET mid-window: returns to reset values on the next edge of CLK.
- BUSY = (state != IDLE).

Decomposition:
- Package osc_mon_pkg holds:
  - state enum {IDLE, ARM, MEASURE};
  - derived widths EDGE_W = $clog2(REF_PERIODS) and TO_W = $clog2(TIMEOUT+1);
  - the range-check function.
- Sub-module osc_sync_edge: 2-flop synchronizer plus rising-edge detector, with synchronous reset to 0. It is reused for other oscillator taps.

Test Plan:
- CLK 20 ns, REF_IN period 1000 ns, EN=1 -> first VALID about 17 us after EN; COUNT=800, IN_RANGE=1; VALID repeats every 16000 ns (800 cycles).
- REF_IN period 1040 ns -> COUNT=832, IN_RANGE=0. Period 1010 ns -> COUNT=808, IN_RANGE=1.
- REF_IN held low after one window -> REF_DEAD=1 exactly TIMEOUT=4096 cycles after the last edge; no further VALID; REF_DEAD holds when edges resume; clears after EN=0.
- EN deasserted mid-window at cycle 400 -> IDLE, no VALID, COUNT keeps previous 800. Re-enable -> normal windows resume.
- CNT_W=8, EXP_COUNT=200, TOL=10, 1000 ns ref -> COUNT=255 saturated, IN_RANGE=0.
- RESET asserted mid-MEASURE -> next cycle all outputs 0 and BUSY=0. First VALID after release comes only after ARM plus a full 16-period window.
